mc_fetch_regs: RTL

//  Multicycle-MIPS datapath register stage driven directly by main_controller outputs.

---
 rtl/mc_pkg.sv | 17 +
 rtl/mc_en_reg.sv | 15 +
 rtl/mc_fetch_regs.sv | 69 ++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared next-PC select codes, opcodes and immediate helper for the multicycle datapath
package mc_pkg;
  localparam logic [1:0] PCSEL_ALU = 2'b00;
  localparam logic [1:0] PCSEL_ALUOUT = 2'b01;
  localparam logic [1:0] PCSEL_JUMP = 2'b10;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J = 6'h02,
    OP_BEQ = 6'h04,
    OP_ADDI = 6'h08,
    OP_LW = 6'h23,
    OP_SW = 6'h2b
  } opcode_t;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/mc_en_reg.sv
// mc_en_reg: register with synchronous reset to RST_VAL and load enable
module mc_en_reg #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input logic clk,
  input logic rst,
  input logic en,
  input logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= RST_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/mc_fetch_regs.sv
// mc_fetch_regs: multicycle MIPS register stage (PC, IR, MDR, A, B, ALUOut) with next-PC and RF/memory steering muxes
module mc_fetch_regs
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic rst,
  input logic IDSel,
  input logic IRWE,
  input logic PCWE,
  input logic Branch,
  input logic [1:0] PCSel,
  input logic RFDSel,
  input logic MtoRFSel,
  input logic zero,
  input logic [31:0] alu_result,
  input logic [31:0] mem_rdata,
  input logic [31:0] rf_rd1,
  input logic [31:0] rf_rd2,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [5:0] op,
  output logic [5:0] funct,
  output logic [4:0] rs,
  output logic [4:0] rt,
  output logic [4:0] rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] a_q,
  output logic [31:0] b_q,
  output logic [31:0] pc_q,
  output logic [31:0] imm_sext,
  output logic [CNT_W-1:0] retired
);
  logic [31:0] ir_q, mdr_q, aluout_q, pc_d;
  logic pc_en;
  mc_en_reg #(.W(32), .RST_VAL(RESET_PC)) u_pc (.clk(CLK), .rst(rst), .en(pc_en), .d(pc_d), .q(pc_q));
  mc_en_reg #(.W(32)) u_ir (.clk(CLK), .rst(rst), .en(IRWE), .d(mem_rdata), .q(ir_q));
  mc_en_reg #(.W(32)) u_mdr (.clk(CLK), .rst(rst), .en(1'b1), .d(mem_rdata), .q(mdr_q));
  mc_en_reg #(.W(32)) u_a (.clk(CLK), .rst(rst), .en(1'b1), .d(rf_rd1), .q(a_q));
  mc_en_reg #(.W(32)) u_b (.clk(CLK), .rst(rst), .en(1'b1), .d(rf_rd2), .q(b_q));
  mc_en_reg #(.W(32)) u_aluout (.clk(CLK), .rst(rst), .en(1'b1), .d(alu_result), .q(aluout_q));
  mc_en_reg #(.W(CNT_W)) u_ret (.clk(CLK), .rst(rst), .en(IRWE), .d(retired + CNT_W'(1)), .q(retired));
  // if/else and case default make any X select fall to the hold/else choice
  always_comb begin
    pc_en = 1'b0;
    if (PCWE) pc_en = 1'b1;
    else if (Branch && zero) pc_en = 1'b1;
    case (PCSel)
      PCSEL_ALU: pc_d = alu_result;
      PCSEL_ALUOUT: pc_d = aluout_q;
      PCSEL_JUMP: pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default: pc_d = pc_q;
    endcase
    mem_addr = pc_q;
    if (IDSel) mem_addr = aluout_q;
    rf_waddr = ir_q[20:16];
    if (RFDSel) rf_waddr = ir_q[15:11];
    rf_wdata = aluout_q;
    if (MtoRFSel) rf_wdata = mdr_q;
  end
  assign mem_wdata = b_q;
  assign op = ir_q[31:26];
  assign funct = ir_q[5:0];
  assign rs = ir_q[25:21];
  assign rt = ir_q[20:16];
  assign imm_sext = sext16(ir_q[15:0]);
endmodule
